// File: rtl/myrisc16_mem_arbiter_pkg.sv
// myrisc16_pkg: shared types and round-robin pick for the myrisc16 memory arbiter
package myrisc16_pkg;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {OWN_CPU = 1'b0, OWN_LDR = 1'b1} owner_t;
  typedef struct packed {
    logic   valid;
    owner_t owner;
  } grant_t;
  // On contention the requester that did not win last time gets the RAM
  function automatic grant_t rr_pick(input logic cpu_elig, input logic ldr_elig, input owner_t last_grant);
    grant_t g;
    g.valid = cpu_elig | ldr_elig;
    g.owner = (cpu_elig & ldr_elig) ? ((last_grant == OWN_CPU) ? OWN_LDR : OWN_CPU)
                                    : (ldr_elig ? OWN_LDR : OWN_CPU);
    return g;
  endfunction
endpackage

// File: rtl/myrisc16_mem_arbiter_if.sv
// myrisc16_mem_arbiter_if: CPU, loader and RAM signals around the memory arbiter
interface myrisc16_mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          in_cpu_req;
  logic          in_cpu_we;
  logic [AW-1:0] in_cpu_addr;
  logic [DW-1:0] in_cpu_wdata;
  logic          out_cpu_ack;
  logic [DW-1:0] out_cpu_rdata;
  logic          in_ldr_session;
  logic          in_ldr_req;
  logic          in_ldr_we;
  logic [AW-1:0] in_ldr_addr;
  logic [DW-1:0] in_ldr_wdata;
  logic          out_ldr_ack;
  logic [DW-1:0] out_ldr_rdata;
  logic          out_cpu_hold;
  logic          out_ram_en;
  logic          out_ram_we;
  logic [AW-1:0] out_ram_addr;
  logic [DW-1:0] out_ram_wdata;
  logic [DW-1:0] in_ram_rdata;
  modport slave (
    input  in_cpu_req, in_cpu_we, in_cpu_addr, in_cpu_wdata,
    input  in_ldr_session, in_ldr_req, in_ldr_we, in_ldr_addr, in_ldr_wdata,
    input  in_ram_rdata,
    output out_cpu_ack, out_cpu_rdata, out_ldr_ack, out_ldr_rdata, out_cpu_hold,
    output out_ram_en, out_ram_we, out_ram_addr, out_ram_wdata
  );
  modport master (
    output in_cpu_req, in_cpu_we, in_cpu_addr, in_cpu_wdata,
    output in_ldr_session, in_ldr_req, in_ldr_we, in_ldr_addr, in_ldr_wdata,
    output in_ram_rdata,
    input  out_cpu_ack, out_cpu_rdata, out_ldr_ack, out_ldr_rdata, out_cpu_hold,
    input  out_ram_en, out_ram_we, out_ram_addr, out_ram_wdata
  );
endinterface

// File: rtl/myrisc16_mem_arbiter.sv
// myrisc16_mem_arbiter: round-robin sharing of one sync RAM between CPU and program loader
module myrisc16_mem_arbiter
  import myrisc16_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = DATA_W
) (
  input  logic                  in_clock,
  input  logic                  in_reset,
  myrisc16_mem_arbiter_if.slave bus
);
  state_t        r_state;
  owner_t        r_owner;
  owner_t        r_last;
  logic          r_cpu_ack;
  logic          r_ldr_ack;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_ldr_rdata;
  logic          r_hold;
  logic          r_ram_en;
  logic          r_ram_we;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_wdata;
  grant_t        w_grant;
  logic          w_ldr;
  // A loader session excludes the CPU from new grants, never from an access in flight
  assign w_grant = rr_pick(bus.in_cpu_req & ~bus.in_ldr_session, bus.in_ldr_req, r_last);
  assign w_ldr   = w_grant.owner == OWN_LDR;
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      r_state     <= IDLE;
      r_owner     <= OWN_CPU;
      r_last      <= OWN_LDR;
      r_cpu_ack   <= 1'b0;
      r_ldr_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_ldr_rdata <= '0;
      r_hold      <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_hold <= bus.in_ldr_session;
      case (r_state)
        IDLE: if (w_grant.valid) begin
          r_ram_en    <= 1'b1;
          r_ram_we    <= w_ldr ? bus.in_ldr_we : bus.in_cpu_we;
          r_ram_addr  <= w_ldr ? bus.in_ldr_addr : bus.in_cpu_addr;
          r_ram_wdata <= w_ldr ? bus.in_ldr_wdata : bus.in_cpu_wdata;
          r_owner     <= w_grant.owner;
          r_last      <= w_grant.owner;
          r_state     <= ISSUE;
        end
        ISSUE: begin
          r_ram_en <= 1'b0;
          r_ram_we <= 1'b0;
          r_state  <= WAIT;
        end
        WAIT: begin
          if (r_owner == OWN_LDR) begin
            r_ldr_rdata <= bus.in_ram_rdata;
            r_ldr_ack   <= 1'b1;
          end else begin
            r_cpu_rdata <= bus.in_ram_rdata;
            r_cpu_ack   <= 1'b1;
          end
          r_state <= RESP;
        end
        default: begin
          r_cpu_ack <= 1'b0;
          r_ldr_ack <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end
  assign bus.out_cpu_ack   = r_cpu_ack;
  assign bus.out_cpu_rdata = r_cpu_rdata;
  assign bus.out_ldr_ack   = r_ldr_ack;
  assign bus.out_ldr_rdata = r_ldr_rdata;
  assign bus.out_cpu_hold  = r_hold;
  assign bus.out_ram_en    = r_ram_en;
  assign bus.out_ram_we    = r_ram_we;
  assign bus.out_ram_addr  = r_ram_addr;
  assign bus.out_ram_wdata = r_ram_wdata;
endmodule

// File: doc/myrisc16_mem_arbiter.md
Name: myrisc16_mem_arbiter

Overview:
Shares one single-port synchronous 16-bit block RAM between the myrisc16 CPU memory port and a program-loader port driven from the PMOD pins. Uses a registered request/acknowledge handshake with round-robin arbitration. A loader session locks out the CPU and raises a hold line that keeps the core stalled while a new program image is written. Sits between myrisc16 and the RAM inside the board top level.

Parameters:
AW, 8, RAM word-address width (depth = 2**AW words)
DW, 16, data width; fixed at 16 for myrisc16 and kept as a parameter only for the bench

Ports:
in_clock  input  1  system clock; all state changes on its rising edge
in_reset  input  1  synchronous active-high reset
in_cpu_req  input  1  CPU access request; level, held until ack
in_cpu_we  input  1  CPU write enable, valid with req
in_cpu_addr  input  AW  CPU word address
in_cpu_wdata  input  DW  CPU write data
out_cpu_ack  output  1  one-cycle completion pulse to CPU
out_cpu_rdata  output  DW  CPU read data, valid while ack high, held afterwards
in_ldr_session  input  1  loader session active; level
in_ldr_req  input  1  loader access request; level, held until ack
in_ldr_we  input  1  loader write enable
in_ldr_addr  input  AW  loader word address
in_ldr_wdata  input  DW  loader write data
out_ldr_ack  output  1  one-cycle completion pulse to loader
out_ldr_rdata  output  DW  loader read data, valid while ack high
out_cpu_hold  output  1  stall/hold line to CPU; high while loader session is active
out_ram_en  output  1  RAM enable, registered
out_ram_we  output  1  RAM write enable, registered
out_ram_addr  output  AW  RAM address, registered
out_ram_wdata  output  DW  RAM write data, registered
in_ram_rdata  input  DW  RAM read data, valid the cycle after en

Behaviour:
- Reset: state=IDLE; all acks, out_ram_en, out_ram_we=0; out_ram_addr, out_ram_wdata, both rdata regs=0; out_cpu_hold=0; last_grant=LDR, so the CPU wins the first contention.
- States: IDLE, ISSUE, WAIT, RESP. A registered owner bit (CPU/LDR) identifies the access in flight.
- IDLE: sample requests. Eligible CPU = in_cpu_req & ~in_ldr_session. Eligible LDR = in_ldr_req.
  - If exactly one is eligible, grant it.
  - If both are eligible, grant the one not equal to last_grant.
  - On grant, at the edge: register en=1, we/addr/wdata from the winner; set owner and last_grant; go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE: RAM sees en high this cycle. At the edge: en=0, we=0; go to WAIT.
- WAIT: in_ram_rdata is valid. At the edge: capture it into the owner's rdata register (reads and writes alike); set the owner's ack=1; go to RESP.
- RESP: the owner's ack is high for exactly this cycle. At the edge: ack=0; go to IDLE.
- Latency: a request sampled at edge E0 produces ack high in the cycle after edge E3 minus one, i.e. the ack is visible during cycle E2..E3. One access completes every 4 cycles minimum, with no back-to-back pipelining.
- The requester drops req (or presents a new access) while seeing ack. IDLE re-samples at the edge ending RESP, so a held req means a new access.
- The non-owner's rdata register and ack are unchanged during an access.
- out_cpu_hold is registered: it follows in_ldr_session with one cycle delay.
- Session rise during a CPU access: the CPU access completes normally. The CPU is only excluded at the next IDLE decision.
- Session fall: CPU becomes eligible at the next IDLE sample.
- Requests that change mid-access are ignored. Winner inputs are captured only at the IDLE→ISSUE edge.
- Reset asserted in any state: next cycle is IDLE with reset values. No ack is produced for an aborted access.
- Addresses wrap naturally at AW bits; no range checking.

Decomposition:
- Package myrisc16_pkg holds:
  - the state encoding (2-bit typedef: IDLE, ISSUE, WAIT, RESP);
  - owner encoding (OWN_CPU=0, OWN_LDR=1);
  - constant DATA_W=16.
- The round-robin pick is a small function in the package: inputs cpu_elig, ldr_elig, last_grant; outputs grant_valid, grant_owner.
- No sub-module: the block is one FSM plus registers.

Test Plan:
- Reset then CPU read: preload RAM[0x05]=0x1234; CPU req, we=0, addr=0x05 → out_ram_en high for exactly 1 cycle, out_cpu_ack pulses 3 cycles after grant edge, out_cpu_rdata=0x1234; out_ldr_ack stays 0.
- Loader write then CPU read: loader writes 0xBEEF to 0x10 → ldr ack pulse; CPU reads 0x10 → rdata=0xBEEF; out_ram_we high only in the ISSUE cycle of the write.
- Simultaneous requests: both req every cycle, session=0, 8 accesses → grants alternate CPU,LDR,CPU,LDR… starting with CPU after reset.
- Loader session lockout: session=1, CPU req held 20 cycles, loader idle → no out_ram_en, out_cpu_hold=1 from cycle after session rise; drop session → CPU granted at next IDLE, ack follows.
- Session rise mid CPU access: raise session during ISSUE → that CPU access still acks; subsequent CPU req not granted.
- Reset mid-access: assert in_reset in WAIT → next cycle all outputs at reset values, no ack; state IDLE; next request serviced normally.
